intrusion_detection_decider: RTL and testbench
==============================================

// Module: intrusion_detection_decider
// PURPOSE
// - Per-packet intrusion classifier on the RDMA RX path, fed by payload_extractor.
// - Consumes one packet's payload beats, accumulates byte-class features and scores them with a linear model.
// - Emits one decision per packet, tagged with the packet's QPN, on a metaIntf.
// PARAMETERS
// - DATA_BITS  512  AXI4S payload width; 64 bytes per beat.
// - CNT_BITS   16   width of each saturating feature counter.
// - W_LEN      0    signed weight, valid payload byte count.
// - W_PRINT    -1   signed weight, printable bytes (0x20..0x7E).
// - W_ZERO     0    signed weight, 0x00 bytes.
// - W_HIGH     1    signed weight, bytes >= 0x80.
// - THRESH     0    signed threshold; intrusion when score > THRESH.
// PORTS
// - nclk                       in   1        clock
// - nresetn                    in   1        reset, asynchronous, active-low
// - s_axis_payload_rx          AXI4S slave  512  payload beats; uses tdata, tkeep, tvalid, tlast, tready
// - meta_rx_i                  in   32       [23:0] QPN of the current packet; [31:24] ignored
// - m_rdma_intrusion_decision  metaIntf master, STYPE logic[24:0]  data[24] = intrusion, data[23:0] = QPN
// BEHAVIOUR
// - Reset (async, nresetn=0): FSM=ACCUM, all counters 0, QPN reg 0, tready=0, decision valid=0, data=0.
// - FSM states and transitions:
//   - ACCUM: tready=1. A handshake occurs when tvalid&tready.
//   - On each handshake, add the beat's features: only bytes with tkeep[i]=1 count.
//   - A byte may hit several classes (e.g. 0x00 counts in LEN and ZERO).
//   - On the first handshake of a packet (first-beat flag), latch meta_rx_i[23:0].
//   - A handshake with tlast=1 adds that beat, then goes to SCORE and re-arms the first-beat flag.
//   - SCORE (1 cycle): tready=0. score = W_LEN*len + W_PRINT*print + W_ZERO*zero + W_HIGH*high.
//     Score is signed 32-bit; register intrusion = (score > THRESH). Go to OUTPUT.
//   - OUTPUT: tready=0, valid=1, data={intrusion, qpn}. Hold data stable until ready.
//     On valid&ready: clear counters, drop valid, return to ACCUM.
// - Latency: valid rises 2 cycles after the tlast handshake when ready is already high.
//   Next packet is accepted the cycle after the decision handshake.
// - Single-beat packet (tlast on first beat) is legal; QPN and features come from that beat.
// - A beat with tkeep=0 is accepted and contributes nothing.
// - Counters saturate at 2^CNT_BITS-1 and do not wrap.
// - Back-pressure: while ready=0 in OUTPUT, tready stays 0. No input is dropped and none is buffered.
// - meta_rx_i is sampled only on the first handshake; changes later in the packet are ignored.
// - Reset mid-packet or mid-output aborts immediately: partial features are discarded and valid drops asynchronously.
// STRUCTURE
// - Package ids_pkg holds:
//   - typedef ids_decision_t = struct packed {logic intrusion; logic [23:0] qpn;} (25 bits).
//   - constants PRINT_LO=8'h20, PRINT_HI=8'h7E, HIGH_LO=8'h80, QPN_BITS=24.
// - Sub-module ids_beat_features (combinational):
//   - inputs: tdata, tkeep.
//   - outputs: 7-bit per-beat counts len, print, zero, high (0..64), built as popcount adder trees.
// - Top level: FSM, saturating accumulators, QPN register, multiply-add score and compare, output register.
// TESTING
// - One beat, all bytes 0x41, tkeep all-ones, tlast=1, meta=0x000011.
//   -> features print=64, high=0, score=-64; data=25'h0000011 (intrusion=0).
// - One beat, all bytes 0xFF, tlast=1, meta=0x0000AB.
//   -> score=+64; data=25'h10000AB (intrusion=1).
// - Three beats, QPN 0x000123: 0xFF x64, 0xFF x64, last beat 0x41 with tkeep=64'h00000fffffffffff.
//   -> len=172, print=44, high=128, score=84; intrusion=1, data=25'h1000123.
// - Back-pressure: hold ready=0 for 10 cycles after valid rises.
//   -> data stable, tready=0, no beat accepted; accepted after the handshake.
// - meta_rx_i changes on beat 2 of a 2-beat packet -> output carries the QPN from beat 1.
// - Reset asserted mid-packet, then a clean 1-beat 0x41 packet.
//   -> only the clean packet's decision (intrusion=0) appears; no residue from the aborted packet.

Source files
------------

// File: rtl/ids_pkg.sv
// ids_pkg: shared types and constants for the intrusion detection decider.
//   ids_decision_t : {intrusion, qpn[23:0]}, 25-bit decision word
//   ids_class_t    : per-byte class hits (len/print/zero/high)
//   ids_state_t    : decider FSM states
//   classify_byte  : maps one byte + keep bit to its class hits
package ids_pkg;

  localparam int         QPN_BITS = 24;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;
  localparam logic [7:0] HIGH_LO  = 8'h80;

  typedef struct packed {
    logic                intrusion;
    logic [QPN_BITS-1:0] qpn;
  } ids_decision_t;

  typedef struct packed {
    logic len;
    logic print;
    logic zero;
    logic high;
  } ids_class_t;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_SCORE  = 2'd1,
    ST_OUTPUT = 2'd2
  } ids_state_t;

  // A byte may land in several classes at once (0x00 is both len and zero).
  // Masked bytes hit nothing.
  function automatic ids_class_t classify_byte(input logic [7:0] b, input logic keep);
    ids_class_t c;
    c.len   = keep;
    c.print = keep && (b >= PRINT_LO) && (b <= PRINT_HI);
    c.zero  = keep && (b == 8'h00);
    c.high  = keep && (b >= HIGH_LO);
    return c;
  endfunction

endpackage

// File: rtl/ids_beat_features.sv
// ids_beat_features: combinational per-beat feature counts.
//   tdata   : NUM_LANES payload bytes
//   tkeep   : byte enables; masked bytes count in no class
//   len     : kept bytes
//   print   : kept bytes in 0x20..0x7E
//   zero    : kept 0x00 bytes
//   high    : kept bytes >= 0x80
module ids_beat_features
  import ids_pkg::*;
#(
  parameter int NUM_LANES = 64,
  parameter int CW        = $clog2(NUM_LANES + 1)
) (
  input  logic [NUM_LANES-1:0][7:0] tdata,
  input  logic [NUM_LANES-1:0]      tkeep,
  output logic [CW-1:0]             len,
  output logic [CW-1:0]             print,
  output logic [CW-1:0]             zero,
  output logic [CW-1:0]             high
);

  logic [NUM_LANES-1:0] hit_len, hit_print, hit_zero, hit_high;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    ids_class_t cls;
    ids_byte_class u_cls (
      .byte_i (tdata[g]),
      .keep_i (tkeep[g]),
      .cls_o  (cls)
    );
    assign hit_len[g]   = cls.len;
    assign hit_print[g] = cls.print;
    assign hit_zero[g]  = cls.zero;
    assign hit_high[g]  = cls.high;
  end

  ids_popcount #(.N(NUM_LANES), .CW(CW)) u_pc_len   (.bits_i(hit_len),   .cnt_o(len));
  ids_popcount #(.N(NUM_LANES), .CW(CW)) u_pc_print (.bits_i(hit_print), .cnt_o(print));
  ids_popcount #(.N(NUM_LANES), .CW(CW)) u_pc_zero  (.bits_i(hit_zero),  .cnt_o(zero));
  ids_popcount #(.N(NUM_LANES), .CW(CW)) u_pc_high  (.bits_i(hit_high),  .cnt_o(high));

endmodule

// File: rtl/ids_byte_class.sv
// ids_byte_class: one byte lane of the beat feature extractor.
//   byte_i : payload byte
//   keep_i : tkeep bit for this byte
//   cls_o  : class hits for this byte
module ids_byte_class
  import ids_pkg::*;
(
  input  logic [7:0] byte_i,
  input  logic       keep_i,
  output ids_class_t cls_o
);

  assign cls_o = classify_byte(byte_i, keep_i);

endmodule

// File: rtl/ids_popcount.sv
// ids_popcount: balanced adder-tree population count.
//   bits_i : N input bits (N must be a power of two)
//   cnt_o  : number of set bits, CW wide
// The tree is stored heap-style: leaves at node[N..2N-1], node[i] sums its
// two children, the root node[1] is the result.
module ids_popcount #(
  parameter int N  = 64,
  parameter int CW = 7
) (
  input  logic [N-1:0]  bits_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] node [1:2*N-1];

  for (genvar j = 0; j < N; j++) begin : g_leaf
    assign node[N+j] = CW'(bits_i[j]);
  end

  for (genvar i = 1; i < N; i++) begin : g_sum
    assign node[i] = node[2*i] + node[2*i+1];
  end

  assign cnt_o = node[1];

endmodule

// File: rtl/intrusion_detection_decider.sv
// intrusion_detection_decider: per-packet linear-model intrusion classifier.
//   nclk, nresetn                       : clock, async active-low reset
//   s_axis_payload_rx_{tdata,tkeep,tvalid,tlast,tready} : payload beats
//   meta_rx_i[23:0]                     : QPN of the current packet
//   m_rdma_intrusion_decision_{valid,ready,data} : {intrusion, qpn}
// Flow: ACCUM (accept beats, accumulate saturating byte-class counters) ->
// SCORE (one cycle, weighted sum vs threshold) -> OUTPUT (hold decision until
// ready). No beat is accepted outside ACCUM, so nothing needs buffering.
module intrusion_detection_decider
  import ids_pkg::*;
#(
  parameter int        DATA_BITS = 512,
  parameter int        CNT_BITS  = 16,
  parameter int signed W_LEN     = 0,
  parameter int signed W_PRINT   = -1,
  parameter int signed W_ZERO    = 0,
  parameter int signed W_HIGH    = 1,
  parameter int signed THRESH    = 0
) (
  input  logic                   nclk,
  input  logic                   nresetn,
  input  logic [DATA_BITS-1:0]   s_axis_payload_rx_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_payload_rx_tkeep,
  input  logic                   s_axis_payload_rx_tvalid,
  input  logic                   s_axis_payload_rx_tlast,
  output logic                   s_axis_payload_rx_tready,
  input  logic [31:0]            meta_rx_i,
  output logic                   m_rdma_intrusion_decision_valid,
  input  logic                   m_rdma_intrusion_decision_ready,
  output logic [24:0]            m_rdma_intrusion_decision_data
);

  localparam int NUM_LANES = DATA_BITS / 8;
  localparam int CW        = $clog2(NUM_LANES + 1);

  typedef logic [CNT_BITS-1:0] cnt_t;

  // Upper meta byte carries nothing for this block.
  logic unused_meta;
  assign unused_meta = ^meta_rx_i[31:24];

  // ---------------- per-beat features ----------------
  logic [CW-1:0] b_len, b_print, b_zero, b_high;

  ids_beat_features #(.NUM_LANES(NUM_LANES), .CW(CW)) u_feat (
    .tdata (s_axis_payload_rx_tdata),
    .tkeep (s_axis_payload_rx_tkeep),
    .len   (b_len),
    .print (b_print),
    .zero  (b_zero),
    .high  (b_high)
  );

  // ---------------- state ----------------
  ids_state_t          state_q, state_d;
  logic                tready_q, tready_d;
  logic                first_q, first_d;
  cnt_t                len_q, len_d;
  cnt_t                print_q, print_d;
  cnt_t                zero_q, zero_d;
  cnt_t                high_q, high_d;
  logic [QPN_BITS-1:0] qpn_q, qpn_d;
  ids_decision_t       dec_q, dec_d;
  logic                valid_q, valid_d;

  function automatic cnt_t sat_add(input cnt_t a, input logic [CW-1:0] b);
    logic [CNT_BITS:0] s;
    s = {1'b0, a} + (CNT_BITS+1)'(b);
    return s[CNT_BITS] ? '1 : s[CNT_BITS-1:0];
  endfunction

  // Counters are unsigned; zero-extend before the signed multiply.
  function automatic logic signed [31:0] term(input int signed w, input cnt_t c);
    return w * signed'(32'(c));
  endfunction

  logic signed [31:0] score;
  assign score = term(W_LEN, len_q) + term(W_PRINT, print_q)
               + term(W_ZERO, zero_q) + term(W_HIGH, high_q);

  logic hs;
  assign hs = s_axis_payload_rx_tvalid && tready_q && (state_q == ST_ACCUM);

  always_comb begin
    state_d  = state_q;
    tready_d = tready_q;
    first_d  = first_q;
    len_d    = len_q;
    print_d  = print_q;
    zero_d   = zero_q;
    high_d   = high_q;
    qpn_d    = qpn_q;
    dec_d    = dec_q;
    valid_d  = valid_q;
    unique case (state_q)
      ST_ACCUM: begin
        // tready comes up one cycle after reset release / decision handshake.
        tready_d = 1'b1;
        if (hs) begin
          len_d   = sat_add(len_q,   b_len);
          print_d = sat_add(print_q, b_print);
          zero_d  = sat_add(zero_q,  b_zero);
          high_d  = sat_add(high_q,  b_high);
          if (first_q) begin
            qpn_d   = meta_rx_i[QPN_BITS-1:0];
            first_d = 1'b0;
          end
          if (s_axis_payload_rx_tlast) begin
            state_d  = ST_SCORE;
            tready_d = 1'b0;
            first_d  = 1'b1;
          end
        end
      end
      ST_SCORE: begin
        dec_d.intrusion = (score > THRESH);
        dec_d.qpn       = qpn_q;
        valid_d         = 1'b1;
        state_d         = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (m_rdma_intrusion_decision_ready) begin
          valid_d  = 1'b0;
          len_d    = '0;
          print_d  = '0;
          zero_d   = '0;
          high_d   = '0;
          tready_d = 1'b1;
          state_d  = ST_ACCUM;
        end
      end
      default: begin
        state_d  = ST_ACCUM;
        tready_d = 1'b0;
        valid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge nclk or negedge nresetn) begin
    if (!nresetn) begin
      state_q  <= ST_ACCUM;
      tready_q <= 1'b0;
      first_q  <= 1'b1;
      len_q    <= '0;
      print_q  <= '0;
      zero_q   <= '0;
      high_q   <= '0;
      qpn_q    <= '0;
      dec_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tready_q <= tready_d;
      first_q  <= first_d;
      len_q    <= len_d;
      print_q  <= print_d;
      zero_q   <= zero_d;
      high_q   <= high_d;
      qpn_q    <= qpn_d;
      dec_q    <= dec_d;
      valid_q  <= valid_d;
    end
  end

  assign s_axis_payload_rx_tready        = tready_q;
  assign m_rdma_intrusion_decision_valid = valid_q;
  assign m_rdma_intrusion_decision_data  = dec_q;

endmodule

// File: tb/tb_intrusion_detection_decider.sv
// Randomized + directed bench for intrusion_detection_decider. A packet-level
// reference model counts byte classes straight from the payload and queues
// the expected decision; a monitor pops it on every decision handshake.
module tb_intrusion_detection_decider;

  localparam int W_LEN = 0, W_PRINT = -1, W_ZERO = 0, W_HIGH = 1, THRESH = 0;
  localparam int SAT = 65535;

  logic         nclk, nresetn;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic         tvalid, tlast, tready;
  logic [31:0]  meta;
  logic         valid, ready;
  logic [24:0]  data;

  intrusion_detection_decider dut (
    .nclk                            (nclk),
    .nresetn                         (nresetn),
    .s_axis_payload_rx_tdata         (tdata),
    .s_axis_payload_rx_tkeep         (tkeep),
    .s_axis_payload_rx_tvalid        (tvalid),
    .s_axis_payload_rx_tlast         (tlast),
    .s_axis_payload_rx_tready        (tready),
    .meta_rx_i                       (meta),
    .m_rdma_intrusion_decision_valid (valid),
    .m_rdma_intrusion_decision_ready (ready),
    .m_rdma_intrusion_decision_data  (data)
  );

  initial begin
    nclk = 0;
    forever #5 nclk = ~nclk;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ready: 0 = always high, 1 = random, 2 = held low. Changes away from negedge.
  int rdy_mode = 0;
  initial begin
    ready = 0;
    forever begin
      @(posedge nclk); #2;
      if (rdy_mode == 1)      ready = 1'($urandom_range(0, 1));
      else if (rdy_mode == 0) ready = 1'b1;
      else                    ready = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  int          m_len, m_print, m_zero, m_high;
  logic [23:0] m_qpn;
  bit          m_first = 1;
  logic [24:0] exp_q[$];

  task automatic model_clear();
    m_len = 0; m_print = 0; m_zero = 0; m_high = 0; m_first = 1;
  endtask

  function automatic int inc_sat(input int v);
    return (v < SAT) ? v + 1 : SAT;
  endfunction

  task automatic model_beat(input logic [511:0] d, input logic [63:0] k,
                            input logic l, input logic [31:0] m);
    longint score;
    if (m_first) begin m_qpn = m[23:0]; m_first = 0; end
    for (int i = 0; i < 64; i++) begin
      int b;
      if (!k[i]) continue;
      b = int'(d[8*i +: 8]);
      m_len = inc_sat(m_len);
      if (b >= 32 && b <= 126) m_print = inc_sat(m_print);
      if (b == 0)              m_zero  = inc_sat(m_zero);
      if (b >= 128)            m_high  = inc_sat(m_high);
    end
    if (l) begin
      score = W_LEN*m_len + W_PRINT*m_print + W_ZERO*m_zero + W_HIGH*m_high;
      exp_q.push_back({(score > THRESH) ? 1'b1 : 1'b0, m_qpn});
      model_clear();
    end
  endtask

  // ---------------- monitor ----------------
  logic [24:0] prev_data;
  bit          prev_stall = 0;
  always @(negedge nclk) begin
    if (!nresetn) prev_stall = 0;
    else if (valid) begin
      chk("tready_in_output", tready, 0);
      if (prev_stall) chk("hold_data", data, prev_data);
      if (ready) begin
        chk("decision_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("decision", data, exp_q.pop_front());
      end
      prev_stall = !ready;
      prev_data  = data;
    end else prev_stall = 0;
  end

  // ---------------- driver ----------------
  bit gaps = 0;

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k,
                           input logic l, input logic [31:0] m);
    int w = 0;
    if (gaps) repeat ($urandom_range(0, 2)) @(posedge nclk);
    #1;
    tvalid = 1; tdata = d; tkeep = k; tlast = l; meta = m;
    @(negedge nclk);
    while (!tready && w < 300) begin @(negedge nclk); w++; end
    if (!tready) begin
      chk("tready_timeout", tready, 1);
      tvalid = 0;
      return;
    end
    @(posedge nclk); #1;
    tvalid = 0;
    model_beat(d, k, l, m);
  endtask

  task automatic wait_valid(input string tag);
    int w = 0;
    @(negedge nclk);
    while (!valid && w < 50) begin @(negedge nclk); w++; end
    chk({tag, "_valid"}, valid, 1);
  endtask

  function automatic logic [511:0] fill(input logic [7:0] b);
    return {64{b}};
  endfunction

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int i = 0; i < 64; i++) begin
      case ($urandom_range(0, 3))
        0:       d[8*i +: 8] = 8'h00;
        1:       d[8*i +: 8] = 8'($urandom_range(32, 126));
        2:       d[8*i +: 8] = 8'($urandom_range(128, 255));
        default: d[8*i +: 8] = 8'($urandom_range(1, 31));
      endcase
    end
    return d;
  endfunction

  initial begin
    logic [511:0] d;
    nresetn = 0; tvalid = 0; tdata = '0; tkeep = '0; tlast = 0; meta = '0;
    model_clear();
    repeat (3) @(posedge nclk);
    @(negedge nclk);
    chk("rst_tready", tready, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    nresetn = 1;

    // single printable beat, with latency check
    send_beat(fill(8'h41), '1, 1, 32'h0000_0011);
    @(negedge nclk); chk("t1_lat_score", valid, 0);
    @(negedge nclk); chk("t1_lat_valid", valid, 1);
    chk("t1_data", data, 25'h0000011);

    // single high beat
    send_beat(fill(8'hFF), '1, 1, 32'h0000_00AB);
    wait_valid("t2"); chk("t2_data", data, 25'h10000AB);

    // three beats, partial keep on the last
    send_beat(fill(8'hFF), '1, 0, 32'h0000_0123);
    send_beat(fill(8'hFF), '1, 0, 32'h0000_0999);
    send_beat(fill(8'h41), 64'h0000_0fff_ffff_ffff, 1, 32'h0000_0777);
    wait_valid("t3"); chk("t3_data", data, 25'h1000123);

    // threshold boundary: score 0 is not an intrusion, score 2 is
    d = fill(8'h41);
    for (int i = 0; i < 32; i++) d[8*i +: 8] = 8'hFF;
    send_beat(d, '1, 1, 32'h0000_0005);
    wait_valid("thr0"); chk("thr0_data", data, 25'h0000005);
    d[8*32 +: 8] = 8'hFF;
    send_beat(d, '1, 1, 32'h0000_0006);
    wait_valid("thr2"); chk("thr2_data", data, 25'h1000006);

    // back-pressure with the next beat already pending
    @(posedge nclk); rdy_mode = 2;
    @(posedge nclk);
    send_beat(fill(8'h41), '1, 1, 32'h0000_0042);
    wait_valid("bp");
    fork
      send_beat(fill(8'hFF), '1, 1, 32'h0000_0043);
      begin
        repeat (10) begin
          @(negedge nclk);
          chk("bp_tready", tready, 0);
          chk("bp_valid", valid, 1);
          chk("bp_data", data, 25'h0000042);
        end
        rdy_mode = 0;
      end
    join
    wait_valid("bp_next"); chk("bp_next_data", data, 25'h1000043);

    // meta changes on beat 2
    send_beat(fill(8'h41), '1, 0, 32'h0000_0077);
    send_beat(fill(8'hFF), '1, 1, 32'h0000_0099);
    wait_valid("meta"); chk("meta_data", data, 25'h0000077);

    // reset mid-packet
    send_beat(fill(8'hFF), '1, 0, 32'h0000_0055);
    @(negedge nclk);
    nresetn = 0; #1;
    chk("rstpkt_tready", tready, 0);
    chk("rstpkt_valid", valid, 0);
    model_clear();
    @(negedge nclk); nresetn = 1;
    send_beat(fill(8'h41), '1, 1, 32'h0000_0066);
    wait_valid("rstpkt"); chk("rstpkt_data", data, 25'h0000066);

    // reset mid-output
    @(posedge nclk); rdy_mode = 2;
    @(posedge nclk);
    send_beat(fill(8'hFF), '1, 1, 32'h0000_0033);
    wait_valid("rstout");
    nresetn = 0; #1;
    chk("rstout_valid", valid, 0);
    chk("rstout_data", data, 0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    model_clear();
    @(negedge nclk); nresetn = 1; rdy_mode = 0;

    // saturation: print overruns 2^16-1, high stays below it
    for (int i = 0; i < 1030; i++) send_beat(fill(8'h41), '1, 0, 32'h0000_0021);
    for (int i = 0; i < 1000; i++) send_beat(fill(8'hFF), '1, i == 999, 32'h0000_0022);
    wait_valid("sat"); chk("sat_data", data, 25'h0000021);

    // random packets, random ready, idle gaps
    rdy_mode = 1; gaps = 1;
    for (int p = 0; p < 30; p++) begin
      int nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        logic [63:0] k;
        case ($urandom_range(0, 3))
          0:       k = '0;
          1:       k = {$urandom, $urandom};
          default: k = '1;
        endcase
        send_beat(rand_data(), k, b == nb - 1, $urandom);
      end
    end

    rdy_mode = 0;
    for (int w = 0; w < 500 && exp_q.size() > 0; w++) @(posedge nclk);
    chk("drain", exp_q.size(), 0);
    repeat (2) @(posedge nclk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
